// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 8x8-bit register file.
// Two producers (ALU result path, memory load path) share the single
// register-file write port through valid/ready handshakes. Grants are
// round-robin, the write port is driven from a registered stage, and a
// per-register busy scoreboard lets the issue logic reserve destinations.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8   // must equal 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,

  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,

  input  logic                  wb_hold,

  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ok,
  output logic [NUM_REGS-1:0]   busy,

  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  output logic                  rf_write_en
);

  // Identity of the most recently granted requester.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  src_e                last;
  logic                xfer;
  logic [NUM_REGS-1:0] busy_next;

  // Round-robin grant: hold and reset block everything, a lone requester
  // wins outright, and under contention the one not granted last wins.
  always_comb begin
    // NOTE: defaults assigned first so every path drives both readys and
    // no latch is inferred.
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst && !wb_hold) begin
      if (alu_valid && mem_valid) begin
        if (last == SRC_MEM) alu_ready = 1'b1;
        else                 mem_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end
    end
  end

  // Readys are only raised alongside their own valid, so either one
  // being high means a transfer is happening this cycle.
  assign xfer = alu_ready | mem_ready;

  // A reservation is accepted only against the current scoreboard, so a
  // register being cleared this cycle still refuses a new reservation.
  assign rsv_ok = ~busy[rsv_addr];

  // Scoreboard update: the write on the port retires its busy bit, then
  // an accepted reservation sets its own bit.
  always_comb begin
    busy_next = busy;
    if (rf_write_en)     busy_next[rf_addr_w] = 1'b0;
    if (rsv_en && rsv_ok) busy_next[rsv_addr] = 1'b1;
  end

  // Registered write stage, priority pointer and scoreboard.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      last        <= SRC_MEM;
      busy        <= '0;
      rf_write_en <= 1'b0;
      rf_addr_w   <= '0;
      rf_data_w   <= '0;
    end else begin
      busy        <= busy_next;
      rf_write_en <= xfer;
      if (xfer) begin
        last      <= mem_ready ? SRC_MEM : SRC_ALU;
        rf_addr_w <= mem_ready ? mem_addr : alu_addr;
        rf_data_w <= mem_ready ? mem_data : alu_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid, alu_ready;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       mem_valid, mem_ready;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       wb_hold;
  logic       rsv_en, rsv_ok;
  logic [2:0] rsv_addr;
  logic [7:0] busy;
  logic [2:0] rf_addr_w;
  logic [7:0] rf_data_w;
  logic       rf_write_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_hold(wb_hold),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy(busy),
    .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .rf_write_en(rf_write_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_last;          // 0 = ALU granted most recently, 1 = MEM
  bit       m_busy [8];
  bit       m_we;
  bit [2:0] m_addr;
  bit [7:0] m_data;
  bit       m_alu_xfer, m_mem_xfer;

  // Returns {mem_grant, alu_grant} from the arbitration rules.
  function automatic logic [1:0] exp_grant(input logic r, input logic h,
                                           input logic av, input logic mv, input bit last);
    if (r || h)      return 2'b00;
    if (av && mv)    return last ? 2'b01 : 2'b10;
    if (av)          return 2'b01;
    if (mv)          return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    bit         ok;
    g = exp_grant(rst, wb_hold, alu_valid, mem_valid, m_last);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_last = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0;
      m_alu_xfer = 1'b0; m_mem_xfer = 1'b0;
    end else begin
      ok = !m_busy[rsv_addr];
      if (m_we) m_busy[m_addr] = 1'b0;
      if (rsv_en && ok) m_busy[rsv_addr] = 1'b1;
      m_alu_xfer = g[0];
      m_mem_xfer = g[1];
      if (g != 2'b00) begin
        m_last = g[1];
        m_we   = 1'b1;
        m_addr = g[1] ? mem_addr : alu_addr;
        m_data = g[1] ? mem_data : alu_data;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Compare process: every cycle, mid-period, all outputs against the model.
  bit model_armed = 1'b0;
  always @(negedge clk) begin
    logic [1:0] g;
    if (model_armed) begin
      g = exp_grant(rst, wb_hold, alu_valid, mem_valid, m_last);
      check("model alu_ready", alu_ready, g[0]);
      check("model mem_ready", mem_ready, g[1]);
      check("model one_ready", alu_ready & mem_ready, 1'b0);
      check("model rsv_ok", rsv_ok, !m_busy[rsv_addr]);
      check("model busy", busy, m_busy_vec());
      check("model rf_write_en", rf_write_en, m_we);
      check("model rf_addr_w", rf_addr_w, m_addr);
      check("model rf_data_w", rf_data_w, m_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    wb_hold = 0; rsv_en = 0; rsv_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  logic [2:0] a_addr_t [3];
  logic [7:0] a_data_t [3];
  logic [2:0] m_addr_t [3];
  logic [7:0] m_data_t [3];
  logic [2:0] w_addr_t [4];
  logic [7:0] w_data_t [4];

  initial begin
    int ai, mi;
    a_addr_t = '{3'd1, 3'd2, 3'd3};  a_data_t = '{8'h11, 8'h22, 8'h33};
    m_addr_t = '{3'd4, 3'd5, 3'd6};  m_data_t = '{8'h44, 8'h55, 8'h66};
    w_addr_t = '{3'd1, 3'd4, 3'd2, 3'd5};
    w_data_t = '{8'h11, 8'h44, 8'h22, 8'h55};

    idle_inputs();
    rst = 1;
    cyc();
    model_armed = 1'b1;
    cyc();
    #2;
    check("reset alu_ready", alu_ready, 1'b0);
    check("reset mem_ready", mem_ready, 1'b0);
    check("reset busy", busy, 8'h00);
    check("reset rf_write_en", rf_write_en, 1'b0);
    check("reset rf_addr_w", rf_addr_w, 3'd0);
    check("reset rf_data_w", rf_data_w, 8'h00);

    // ALU only
    rst = 0;
    alu_valid = 1; alu_addr = 3; alu_data = 8'hA5;
    #2 check("alu_only ready", alu_ready, 1'b1);
    cyc(); alu_valid = 0;
    #2;
    check("alu_only we", rf_write_en, 1'b1);
    check("alu_only addr", rf_addr_w, 3'd3);
    check("alu_only data", rf_data_w, 8'hA5);
    cyc();
    #2 check("alu_only we_drop", rf_write_en, 1'b0);

    // Contention: ALU, MEM, ALU, MEM
    do_reset();
    ai = 0; mi = 0;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1; alu_addr = a_addr_t[ai]; alu_data = a_data_t[ai];
      mem_valid = 1; mem_addr = m_addr_t[mi]; mem_data = m_data_t[mi];
      #2;
      check("contend alu_ready", alu_ready, (k % 2) == 0);
      check("contend mem_ready", mem_ready, (k % 2) == 1);
      if (k > 0) begin
        check("contend wb_addr", rf_addr_w, w_addr_t[k-1]);
        check("contend wb_data", rf_data_w, w_data_t[k-1]);
      end
      if (alu_ready) ai++;
      if (mem_ready) mi++;
      cyc();
    end
    alu_valid = 0; mem_valid = 0;
    #2;
    check("contend last_we", rf_write_en, 1'b1);
    check("contend last_addr", rf_addr_w, 3'd5);
    check("contend last_data", rf_data_w, 8'h55);
    cyc();

    // Scoreboard: reserve R5, re-reserve refused, MEM write clears
    rsv_en = 1; rsv_addr = 5;
    #2 check("sb first rsv_ok", rsv_ok, 1'b1);
    cyc();
    #2;
    check("sb busy set", busy, 8'h20);
    check("sb second rsv_ok", rsv_ok, 1'b0);
    cyc();
    rsv_en = 0;
    mem_valid = 1; mem_addr = 5; mem_data = 8'h3C;
    #2;
    check("sb busy unchanged", busy, 8'h20);
    check("sb mem_ready", mem_ready, 1'b1);
    cyc(); mem_valid = 0;
    #2;
    check("sb wb_addr", rf_addr_w, 3'd5);
    check("sb wb_data", rf_data_w, 8'h3C);
    check("sb busy during write", busy, 8'h20);
    cyc();
    #2 check("sb busy cleared", busy, 8'h00);

    // Same-cycle clear and reserve of the same / a different register
    for (int rep = 0; rep < 2; rep++) begin
      rsv_en = 1; rsv_addr = 2;
      cyc();
      rsv_en = 0;
      alu_valid = 1; alu_addr = 2; alu_data = 8'h77;
      cyc();
      alu_valid = 0;
      rsv_en = 1; rsv_addr = (rep == 0) ? 3'd2 : 3'd6;
      #2;
      check("clr_rsv we", rf_write_en, 1'b1);
      if (rep == 0) check("clr_rsv same rsv_ok", rsv_ok, 1'b0);
      cyc();
      rsv_en = 0;
      #2 check("clr_rsv busy", busy, (rep == 0) ? 8'h00 : 8'h40);
      cyc();
    end

    // wb_hold stalls both requesters; ALU goes first on release
    do_reset();
    wb_hold = 1;
    alu_valid = 1; alu_addr = 1; alu_data = 8'hA1;
    mem_valid = 1; mem_addr = 6; mem_data = 8'hB6;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("hold alu_ready", alu_ready, 1'b0);
      check("hold mem_ready", mem_ready, 1'b0);
      check("hold we", rf_write_en, 1'b0);
      cyc();
    end
    wb_hold = 0;
    #2 check("release alu first", alu_ready, 1'b1);
    cyc(); alu_valid = 0;
    #2;
    check("release mem next", mem_ready, 1'b1);
    check("release wb_data alu", rf_data_w, 8'hA1);
    cyc(); mem_valid = 0;
    #2 check("release wb_data mem", rf_data_w, 8'hB6);
    cyc();

    // Reset mid-operation
    mem_valid = 1; mem_addr = 4; mem_data = 8'h44;
    rsv_en = 1; rsv_addr = 7;
    #2 check("midrst mem_ready", mem_ready, 1'b1);
    cyc();
    mem_valid = 0; rsv_en = 0; rst = 1;
    #2 check("midrst readys in reset", {alu_ready, mem_ready}, 2'b00);
    cyc();
    rst = 0;
    #2;
    check("midrst we", rf_write_en, 1'b0);
    check("midrst busy", busy, 8'h00);
    alu_valid = 1; alu_addr = 0; alu_data = 8'h01;
    mem_valid = 1; mem_addr = 1; mem_data = 8'h02;
    #1 check("midrst alu wins", alu_ready, 1'b1);
    cyc();

    // Randomized traffic; a stalled requester keeps its addr/data.
    for (int c = 0; c < 3000; c++) begin
      if (!(alu_valid && !m_alu_xfer)) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_addr  = 3'($urandom);
        alu_data  = 8'($urandom);
      end
      if (!(mem_valid && !m_mem_xfer)) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_addr  = 3'($urandom);
        mem_data  = 8'($urandom);
      end
      wb_hold  = ($urandom_range(0, 4) == 0);
      rsv_en   = ($urandom_range(0, 9) < 4);
      rsv_addr = 3'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
      cyc();
    end

    idle_inputs();
    rst = 0;
    cyc();
    model_armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
